mic_i2s_capture: RTL
====================

Name: mic_i2s_capture

Overview:
- I2S master receiver for the PCM microphone path.
- Generates the bit clock (sck) and word select (ws) for an I2S MEMS microphone, and deserialises the selected channel's MSBs into a DAT_WIDTH-bit sample.
- Pushes each sample into the downstream sample FIFO with a single-cycle write strobe.
- Sits directly upstream of that FIFO and shares its mclk domain. It drops and counts samples when the FIFO reports full.

Parameters:
- CLK_DIV, 4: mclk cycles per sck half-period; legal range is 2 or more.
- SLOT_BITS, 32: sck periods per channel slot; a frame is 2*SLOT_BITS sck periods.
- DAT_WIDTH, 6: captured sample width, matching the FIFO data width; legal range is 1 to SLOT_BITS-1.
- CHANNEL, 0: captured slot; 0 = left (ws low), 1 = right (ws high).

Ports:
- mclk  in  1  system/master clock.
- reset  in  1  synchronous, active-high; clock mclk.
- en  in  1  capture enable; when low, the interface is idle.
- sd  in  1  serial data from the microphone, MSB first.
- sck  out  1  I2S bit clock.
- ws  out  1  I2S word select (lr).
- fifo_full  in  1  full flag from the downstream FIFO.
- sample  out  DAT_WIDTH  last assembled sample; drives the FIFO data_in.
- wr  out  1  FIFO write strobe, one mclk cycle per accepted sample.
- overrun  out  1  sticky flag; set when a sample is dropped.
- drop_cnt  out  8  count of dropped samples, saturating at 255.
- clr_ovr  in  1  clears overrun and drop_cnt.

Behaviour:
- Reset (reset=1 at a mclk edge):
  - All outputs go to 0: sck, ws, sample, wr, overrun, drop_cnt.
  - The divider, bit counter and shift register are cleared.
  - Reset mid-frame abandons the partial sample; no wr is issued.
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - At terminal count, sck toggles and div_cnt returns to 0.
  - A "rise event" is the mclk cycle in which sck goes 0->1; a "fall event" is the cycle in which it goes 1->0.
  - sck period = 2*CLK_DIV mclk cycles.
- Bit counter:
  - bit_cnt counts 0..2*SLOT_BITS-1 and advances on each fall event, wrapping to 0.
  - ws is registered as (bit_cnt >= SLOT_BITS) and therefore changes only on fall events.
  - slot_bit = bit_cnt mod SLOT_BITS.
- Capture:
  - On a rise event, sd is sampled when the current slot matches CHANNEL and 1 <= slot_bit <= DAT_WIDTH.
  - This follows standard I2S: the MSB arrives one sck after the ws transition.
  - The sampled bit is shifted into the shift register LSB, so the MSB ends up at bit DAT_WIDTH-1.
  - Bits with slot_bit 0 or slot_bit > DAT_WIDTH are ignored.
- Push (at the rise event capturing slot_bit==DAT_WIDTH, with push on the next mclk cycle):
  - If fifo_full=0:
    - sample is loaded with the complete word.
    - wr=1 for exactly one mclk cycle.
  - If fifo_full=1:
    - sample and wr are unchanged (wr stays 0).
    - overrun is set to 1.
    - drop_cnt increments, saturating at 255.
  - fifo_full is evaluated in the push cycle only.
  - sample holds its value between pushes.
- Throughput: one push attempt per frame = 4*SLOT_BITS*CLK_DIV mclk cycles.
- clr_ovr=1:
  - Clears overrun to 0 and drop_cnt to 0.
  - If a drop occurs in the same cycle, the drop wins: overrun=1, drop_cnt=1.
- en:
  - en=0: sck=0, ws=0, div_cnt and bit_cnt held at 0, shift register cleared, wr=0.
  - sample, overrun and drop_cnt are retained.
  - Deasserting en mid-frame discards the partial word.
  - After en rises, the first rise event occurs CLK_DIV cycles later, with bit_cnt=0 and ws=0.
- wr is never asserted on two consecutive cycles and never while reset=1.

Test Plan (CLK_DIV=2, SLOT_BITS=32, DAT_WIDTH=6, CHANNEL=0; frame = 256 mclk cycles):
1. Reset and clocking: hold reset for 3 cycles, then set en=1. Required: all outputs 0 during reset; sck period 4 cycles; ws low for 128 cycles then high for 128; ws toggles coincident with sck falling.
2. Basic capture: I2S mic model drives left word MSBs 101101 and right word 010010; fifo_full=0. Required: sample=6'h2D with exactly one wr per frame; the right word is never captured; wr occurs 1 cycle after the 6th left-slot rise event.
3. Right channel: CHANNEL=1 with the same stimulus. Required: sample=6'h12, one wr per frame.
4. Overrun: fifo_full=1 for 3 frames, then 0. Required: no wr during the full frames; overrun=1; drop_cnt=3; next frame pushes normally and overrun stays 1. Drive clr_ovr coincident with a drop. Required: drop_cnt=1.
5. Saturation: fifo_full=1 for 260 frames. Required: drop_cnt=255.
6. Mid-frame disruption: pulse reset, and separately drop en, at left-slot bit 3. Required: no wr for the partial word; after en rises, capture restarts at bit_cnt=0 and the next full left word is pushed correctly.

Source files
------------

// File: rtl/mic_i2s_capture.sv
// mic_i2s_capture: I2S master receiver that generates sck/ws, deserialises one channel and pushes samples to a FIFO
module mic_i2s_capture #(
  parameter int CLK_DIV   = 4,
  parameter int SLOT_BITS = 32,
  parameter int DAT_WIDTH = 6,
  parameter int CHANNEL   = 0
) (
  input  logic                 mclk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 sd,
  output logic                 sck,
  output logic                 ws,
  input  logic                 fifo_full,
  output logic [DAT_WIDTH-1:0] sample,
  output logic                 wr,
  output logic                 overrun,
  output logic [7:0]           drop_cnt,
  input  logic                 clr_ovr
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam logic P_CH = CHANNEL != 0;
  logic [DW-1:0]        r_div;
  logic [BW-1:0]        r_bit;
  logic [DAT_WIDTH-1:0] r_shift;
  logic                 r_push;
  logic                 w_tc, w_rise, w_fall, w_hi, w_cap, w_push;
  logic [BW-1:0]        w_slot, w_bit_nxt;
  assign w_tc      = r_div == DW'(CLK_DIV - 1);
  assign w_rise    = w_tc && !sck;
  assign w_fall    = w_tc && sck;
  assign w_hi      = r_bit >= BW'(SLOT_BITS);
  assign w_slot    = w_hi ? r_bit - BW'(SLOT_BITS) : r_bit;
  assign w_bit_nxt = (r_bit == BW'(2 * SLOT_BITS - 1)) ? '0 : r_bit + 1'b1;
  // slot_bit 0 carries the previous word's LSB; the MSB follows one sck later
  assign w_cap     = w_rise && (w_hi == P_CH) && w_slot >= BW'(1) && w_slot <= BW'(DAT_WIDTH);
  assign w_push    = r_push && en;
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_push   <= 1'b0;
      sck      <= 1'b0;
      ws       <= 1'b0;
      sample   <= '0;
      wr       <= 1'b0;
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr <= 1'b0;
      if (!en) begin
        r_div   <= '0;
        r_bit   <= '0;
        r_shift <= '0;
        r_push  <= 1'b0;
        sck     <= 1'b0;
        ws      <= 1'b0;
      end else begin
        r_div  <= w_tc ? '0 : r_div + 1'b1;
        r_push <= w_cap && w_slot == BW'(DAT_WIDTH);
        if (w_tc) sck <= !sck;
        if (w_fall) begin
          r_bit <= w_bit_nxt;
          ws    <= w_bit_nxt >= BW'(SLOT_BITS);
        end
        if (w_cap) r_shift <= DAT_WIDTH'({r_shift, sd});
      end
      if (clr_ovr) begin
        overrun  <= 1'b0;
        drop_cnt <= '0;
      end
      if (w_push && !fifo_full) begin
        sample <= r_shift;
        wr     <= 1'b1;
      end
      // a drop in the same cycle as clr_ovr leaves exactly this one drop counted
      if (w_push && fifo_full) begin
        overrun  <= 1'b1;
        drop_cnt <= clr_ovr ? 8'd1 : drop_cnt + (&drop_cnt ? 8'd0 : 8'd1);
      end
    end
  end
endmodule
